gcd_8bit: RTL and testbench

//   Sequential subtractive GCD unit for two unsigned 8-bit operands, with a start/done handshake.

---
 rtl/gcd_8bit_pkg.sv | 13 +
 rtl/gcd_datapath_8bit.sv | 62 ++++++
 rtl/mux2_1_8bit.sv | 14 +
 rtl/gcd_8bit.sv | 89 ++++++++
 tb/tb_gcd_8bit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gcd_8bit_pkg.sv
// Shared definitions for the 8-bit subtractive GCD unit: operand width and
// controller state codes.
package gcd_8bit_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    GCD_IDLE = 2'd0,
    GCD_CALC = 2'd1,
    GCD_DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_datapath_8bit.sv
// GCD datapath: operand registers fed by the select muxes, a shared
// subtractor, compare flags and the result register.
module gcd_datapath_8bit
  import gcd_8bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GCD_WIDTH-1:0] a_in,
  input  logic [GCD_WIDTH-1:0] b_in,
  input  logic                 sel_load,
  input  logic                 en_a,
  input  logic                 en_b,
  input  logic                 en_r,
  output logic                 a_gt_b,
  output logic                 a_eq_b,
  output logic                 a_zero,
  output logic                 b_zero,
  output logic [GCD_WIDTH-1:0] result
);

  logic [GCD_WIDTH-1:0] reg_a;
  logic [GCD_WIDTH-1:0] reg_b;
  logic [GCD_WIDTH-1:0] diff;
  logic [GCD_WIDTH-1:0] next_a;
  logic [GCD_WIDTH-1:0] next_b;

  assign a_gt_b = reg_a > reg_b;
  assign a_eq_b = reg_a == reg_b;
  assign a_zero = reg_a == '0;
  assign b_zero = reg_b == '0;

  // Larger minus smaller, so the difference never wraps.
  assign diff = a_gt_b ? (reg_a - reg_b) : (reg_b - reg_a);

  mux2_1_8bit u_mux_a (
    .d0  (diff),
    .d1  (a_in),
    .sel (sel_load),
    .y   (next_a)
  );

  mux2_1_8bit u_mux_b (
    .d0  (diff),
    .d1  (b_in),
    .sel (sel_load),
    .y   (next_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      result <= '0;
    end else begin
      if (en_a) reg_a <= next_a;
      if (en_b) reg_b <= next_b;
      // A zero A means B already holds the answer (covers GCD(0,0)=0).
      if (en_r) result <= a_zero ? reg_b : reg_a;
    end
  end

endmodule

// File: rtl/mux2_1_8bit.sv
// 8-bit 2:1 operand-select mux: sel=1 picks the external operand,
// sel=0 picks the subtractor result.
module mux2_1_8bit
  import gcd_8bit_pkg::*;
(
  input  logic [GCD_WIDTH-1:0] d0,
  input  logic [GCD_WIDTH-1:0] d1,
  input  logic                 sel,
  output logic [GCD_WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/gcd_8bit.sv
// Sequential subtractive GCD with start/done handshake: controller FSM
// driving the operand selects and register enables of the datapath.
//
//   state    | meaning
//   GCD_IDLE | waiting for start
//   GCD_CALC | one compare/subtract step per cycle (busy)
//   GCD_DONE | result valid, done pulse; start here reloads back-to-back
module gcd_8bit
  import gcd_8bit_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  gcd_state_t state;
  logic       sel_load;
  logic       en_a;
  logic       en_b;
  logic       en_r;
  logic       a_gt_b;
  logic       a_eq_b;
  logic       a_zero;
  logic       b_zero;
  logic       finish;

  assign finish = a_zero || b_zero || a_eq_b;
  assign busy   = state == GCD_CALC;
  assign done   = state == GCD_DONE;

  always_comb begin
    sel_load = 1'b0;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_r     = 1'b0;
    case (state)
      GCD_IDLE, GCD_DONE: begin
        if (start) begin
          sel_load = 1'b1;
          en_a     = 1'b1;
          en_b     = 1'b1;
        end
      end
      GCD_CALC: begin
        if (finish)      en_r = 1'b1;
        else if (a_gt_b) en_a = 1'b1;
        else             en_b = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GCD_IDLE;
    end else begin
      case (state)
        GCD_IDLE: if (start) state <= GCD_CALC;
        GCD_CALC: if (finish) state <= GCD_DONE;
        GCD_DONE: state <= start ? GCD_CALC : GCD_IDLE;
        default:  state <= GCD_IDLE;
      endcase
    end
  end

  gcd_datapath_8bit u_datapath (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .sel_load (sel_load),
    .en_a     (en_a),
    .en_b     (en_b),
    .en_r     (en_r),
    .a_gt_b   (a_gt_b),
    .a_eq_b   (a_eq_b),
    .a_zero   (a_zero),
    .b_zero   (b_zero),
    .result   (result)
  );

endmodule

// File: tb/tb_gcd_8bit.sv
// Scoreboard bench for gcd_8bit: the driver queues expected result/latency
// per accepted start, the monitor checks them whenever done is seen.
module tb_gcd_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;

  typedef struct {
    int res;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  gcd_8bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("busy_low_in_done", int'(busy), 0);
        check("done_one_cycle", int'(prev_done), 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done result=%0d expected=no_done (cycle %0d)", result, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", int'(result), e.res);
          if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_ready_timeout busy=%0d done=%0d", busy, done);
    end
  endtask

  task automatic accept(input int a, input int b, input int exp, input int lat);
    exp_t e;
    start = 1'b1;
    a_in  = 8'(a);
    b_in  = 8'(b);
    @(posedge clk);
    #1;
    e.res = exp;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
    @(negedge clk);
    check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic issue(input int a, input int b, input int exp, input int lat);
    wait_ready();
    accept(a, b, exp, lat);
  endtask

  // Hold start into the DONE cycle so the next operation starts back-to-back.
  task automatic issue_b2b(input int a, input int b, input int exp, input int lat);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL wait_done_timeout done=%0d expected=1", done);
    end
    accept(a, b, exp, lat);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int ra;
    int rb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);

    issue(12, 8, 4, 3);
    drain();
    repeat (3) @(negedge clk);
    check("result_held_idle", int'(result), 4);
    check("idle_busy", int'(busy), 0);

    issue(255, 1, 1, 255);
    issue(7, 7, 7, 1);
    issue(0, 9, 9, 1);
    issue(9, 0, 9, 1);
    issue(0, 0, 0, 1);
    drain();

    // start pulsed during CALC must be ignored
    issue(100, 75, 25, 4);
    start = 1'b1;
    a_in  = 8'd9;
    b_in  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    issue_b2b(21, 14, 7, 3);
    drain();

    // reset in the middle of a long computation
    wait_ready();
    start = 1'b1;
    a_in  = 8'd200;
    b_in  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midop_reset_busy", int'(busy), 0);
    check("midop_reset_done", int'(done), 0);
    check("midop_reset_result", int'(result), 0);
    repeat (10) @(negedge clk);
    issue(48, 18, 6, 5);
    drain();

    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      issue(ra, rb, ref_gcd(ra, rb), -1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
